// File: rtl/demux8_deserializer.sv
// demux8_deserializer: 1:8 serial-to-parallel demux with a valid/ready output register
// clk, rst (async, active-high); din/din_valid serial input; frame_start realigns to bit 0;
// y/y_valid/y_ready word output handshake; lane_idx next bit index; overrun sticky drop flag, clr_ovr clears it
module demux8_deserializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_start,
  output logic [7:0] y,
  output logic       y_valid,
  input  logic       y_ready,
  output logic [2:0] lane_idx,
  output logic       overrun,
  input  logic       clr_ovr
);
  logic [2:0] idx, idx_n, bit_k, lane;
  logic [7:0] asm_reg, asm_n;
  logic       complete, free;
  assign lane_idx = idx;
  assign bit_k    = frame_start ? 3'd0 : idx;
  assign lane     = MSB_FIRST ? 3'd7 - bit_k : bit_k;
  assign complete = din_valid && !frame_start && idx == 3'd7;
  assign free     = !y_valid || y_ready;
  assign idx_n    = frame_start ? {2'b00, din_valid} : din_valid ? idx + 3'd1 : idx;
  // asm_n doubles as the candidate word on the completing cycle
  always_comb begin
    asm_n = asm_reg;
    if (din_valid) asm_n[lane] = din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= 3'd0;
      asm_reg <= 8'h00;
      y       <= 8'h00;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      idx     <= idx_n;
      asm_reg <= asm_n;
      if (complete && free) begin
        y       <= asm_n;
        y_valid <= 1'b1;
      end else if (y_ready) y_valid <= 1'b0;
      overrun <= (complete && !free) || (overrun && !clr_ovr);
    end
  end
endmodule
